// File: rtl/imem_pkg.sv
// Shared types, constants and the address check
// used by the instruction memory fetch port.
package imem_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_RANGE    = 2'b10;

  typedef enum logic {
    RSP_EMPTY = 1'b0,
    RSP_FULL  = 1'b1
  } rsp_state_e;

  // Misalignment takes priority over range.
  function automatic logic [1:0] addr_fault(
    input logic [63:0] addr,
    input logic [63:0] depth
  );
    if (addr[1:0] != 2'b00) return FAULT_MISALIGN;
    if (addr >= (depth << 2)) return FAULT_RANGE;
    return FAULT_NONE;
  endfunction

endpackage

// File: rtl/imem_fetch_port_ram.sv
// Synchronous RAM: one read port, one write port,
// read-first, contents start as the NOP word.
module imem_ram #(
  parameter int          DEPTH = 1024,
  parameter int          WIDTH = 32,
  parameter logic [31:0] INIT  = 32'h00000013,
  localparam int         AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata
);

  logic [WIDTH-1:0] mem_q [DEPTH] = '{default: INIT[WIDTH-1:0]};
  logic [WIDTH-1:0] rdata_q;

  // Read-first: a same-word write is seen by the next read.
  always_ff @(posedge clk) begin
    if (re) rdata_q <= mem_q[raddr];
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/imem_fetch_port.sv
// Fetch-side instruction memory: valid/ready request,
// one-cycle registered response, load port, faults.
module imem_fetch_port
  import imem_pkg::*;
#(
  parameter int          ADDR_W = 32,
  parameter int          DEPTH  = 1024,
  parameter logic [31:0] NOP    = NOP_INSTR
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_instr,
  output logic [1:0]        rsp_fault,
  input  logic              flush,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data
);

  localparam int IDX_W = $clog2(DEPTH);

  rsp_state_e  state_q;
  logic [1:0]  fault_q;
  logic [1:0]  fault_d;
  logic        src_ram_q;
  logic        src_ram_d;
  logic        accept;
  logic        load_ok;
  logic [31:0] ram_rdata;

  assign rsp_valid = (state_q == RSP_FULL);
  assign req_ready = !flush && (!rsp_valid || rsp_ready);
  assign accept    = req_valid && req_ready;

  assign load_ok = load_en &&
    (addr_fault(64'(load_addr), 64'(DEPTH)) == FAULT_NONE);

  // Classify the request; only clean fetches use RAM data.
  always_comb begin
    fault_d   = addr_fault(64'(req_addr), 64'(DEPTH));
    src_ram_d = (fault_d == FAULT_NONE);
  end

  imem_ram #(
    .DEPTH (DEPTH),
    .WIDTH (32),
    .INIT  (NOP)
  ) u_ram (
    .clk   (clk),
    .re    (accept),
    .raddr (req_addr[IDX_W+1:2]),
    .rdata (ram_rdata),
    .we    (load_ok),
    .waddr (load_addr[IDX_W+1:2]),
    .wdata (load_data)
  );

  // Response slot: EMPTY/FULL with captured fault tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RSP_EMPTY;
      fault_q   <= FAULT_NONE;
      src_ram_q <= 1'b0;
    end else if (flush) begin
      state_q <= RSP_EMPTY;
    end else if (accept) begin
      state_q   <= RSP_FULL;
      fault_q   <= fault_d;
      src_ram_q <= src_ram_d;
    end else if (rsp_ready) begin
      state_q <= RSP_EMPTY;
    end
  end

  assign rsp_instr = src_ram_q ? ram_rdata : NOP;
  assign rsp_fault = fault_q;

endmodule

// File: tb/tb_imem_fetch_port.sv
// Directed bench for imem_fetch_port with a
// response scoreboard and immediate assertions.
module tb_imem_fetch_port;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] NOPW  = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_instr;
  logic [1:0]  rsp_fault;
  logic        flush;
  logic        load_en;
  logic [31:0] load_addr;
  logic [31:0] load_data;

  int npass = 0;
  int ntot  = 0;

  logic [31:0] mem_m [DEPTH];
  logic [33:0] sb_q [$];

  imem_fetch_port #(
    .ADDR_W (32),
    .DEPTH  (DEPTH),
    .NOP    (NOPW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_instr (rsp_instr),
    .rsp_fault (rsp_fault),
    .flush     (flush),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
  endtask

  function automatic logic [33:0] model_rsp(
    input logic [31:0] a);
    if (a[1:0] != 2'b00) return {2'b01, NOPW};
    if (a >= 32'(DEPTH * 4)) return {2'b10, NOPW};
    return {2'b00, mem_m[a[11:2]]};
  endfunction

  // One clock: drive, score pre-edge, then advance.
  task automatic step(input bit rv, input logic [31:0] ra,
                      input bit rr, input bit fl,
                      input bit le, input logic [31:0] la,
                      input logic [31:0] ld);
    logic [33:0] e;
    bit acc;
    bit cons;
    req_valid = rv;
    req_addr  = ra;
    rsp_ready = rr;
    flush     = fl;
    load_en   = le;
    load_addr = la;
    load_data = ld;
    #1;
    acc  = req_valid && req_ready;
    cons = rsp_valid && rsp_ready && !flush;
    if (cons) begin
      chk("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("rsp_instr", 64'(rsp_instr), 64'(e[31:0]));
        chk("rsp_fault", 64'(rsp_fault), 64'(e[33:32]));
      end
    end else if (flush && rsp_valid && sb_q.size() != 0) begin
      void'(sb_q.pop_front());
    end
    if (acc) sb_q.push_back(model_rsp(ra));
    if (le && la[1:0] == 2'b00 && la < 32'(DEPTH * 4))
      mem_m[la[11:2]] = ld;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit rr);
    step(1'b0, 32'h0, rr, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic fetch(input logic [31:0] a, input bit rr);
    step(1'b1, a, rr, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic load(input logic [31:0] a,
                      input logic [31:0] d);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, a, d);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem_m[i] = NOPW;
    rst_n = 1'b0;
    req_valid = 0; req_addr = 0; rsp_ready = 0;
    flush = 0; load_en = 0; load_addr = 0; load_data = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;

    chk("rst_valid", 64'(rsp_valid), 64'd0);
    chk("rst_instr", 64'(rsp_instr), 64'(NOPW));
    chk("rst_fault", 64'(rsp_fault), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd1);
    rst_n = 1'b1;

    // Fresh memory reads back NOP.
    fetch(32'h0, 1'b1);
    chk("lat_valid", 64'(rsp_valid), 64'd1);
    idle(1'b1);
    chk("drain_valid", 64'(rsp_valid), 64'd0);

    // Load then back-to-back stream.
    load(32'h0, 32'h00500093);
    load(32'h4, 32'h00100113);
    fetch(32'h0, 1'b1);
    chk("stream_v0", 64'(rsp_valid), 64'd1);
    fetch(32'h4, 1'b1);
    chk("stream_v1", 64'(rsp_valid), 64'd1);
    fetch(32'h8, 1'b1);
    chk("stream_v2", 64'(rsp_valid), 64'd1);
    idle(1'b1);

    // Stall with reload underneath the held word.
    fetch(32'h4, 1'b1);
    step(1'b1, 32'h4, 1'b0, 1'b0, 1'b1, 32'h4, 32'hDEADBEEF);
    for (int k = 0; k < 3; k++) begin
      chk("stall_ready", 64'(req_ready), 64'd0);
      chk("stall_instr", 64'(rsp_instr), 64'h00100113);
      if (k < 2) fetch(32'h4, 1'b0);
    end
    fetch(32'h4, 1'b1);
    idle(1'b1);

    // Faults and a dropped out-of-range load.
    fetch(32'h2, 1'b1);
    fetch(32'h1000, 1'b1);
    load(32'h1000, 32'hCAFEF00D);
    fetch(32'h0, 1'b1);
    idle(1'b1);

    // Flush with request held high.
    fetch(32'h0, 1'b1);
    step(1'b1, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    chk("flush_valid", 64'(rsp_valid), 64'd0);
    fetch(32'h0, 1'b0);
    chk("post_flush_acc", 64'(rsp_valid), 64'd1);
    idle(1'b1);

    // Same-word read/write collision.
    step(1'b1, 32'h8, 1'b1, 1'b0, 1'b1, 32'h8, 32'h11111111);
    fetch(32'h8, 1'b1);
    idle(1'b1);

    // Asynchronous reset with a pending response.
    fetch(32'h4, 1'b0);
    chk("pre_rst_valid", 64'(rsp_valid), 64'd1);
    req_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(rsp_valid), 64'd0);
    chk("arst_instr", 64'(rsp_instr), 64'(NOPW));
    chk("arst_fault", 64'(rsp_fault), 64'd0);
    sb_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    fetch(32'h0, 1'b1);
    idle(1'b1);

    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
